// File: rtl/resp_chk_pkg.sv
// ---------------------------------------------------------------------------
// resp_chk_pkg
//   Shared types and helpers for the response MISR checker.
//   - MISR_W    : signature / sampled-bus width (the `y` bus of `top`)
//   - state_t   : checker FSM states
//   - misr_step : one Galois MISR update (shift, conditional feedback, fold in)
// ---------------------------------------------------------------------------
package resp_chk_pkg;

  localparam int MISR_W = 245;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift left by one; when the MSB falls out, the feedback mask is XORed in.
  // The new sample is folded in last, so a zero sample is a pure LFSR step.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    return ({sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0)) ^ data;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// ---------------------------------------------------------------------------
// misr_reg
//   Signature register of the response checker.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset (loads SEED)
//     load in   reload SEED at the start of a run (wins over step)
//     step in   fold `data` into the signature this cycle
//     data in   sampled bus
//     sig  out  current signature
// ---------------------------------------------------------------------------
module misr_reg
  import resp_chk_pkg::*;
#(
  parameter int                DATA_W = MISR_W,
  parameter logic [DATA_W-1:0] POLY   = {{(DATA_W-8){1'b0}}, 8'h8E},
  parameter logic [DATA_W-1:0] SEED   = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sig
);

  // NOTE: sequential state is always written with <= so every register in the
  // design samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= SEED;
    end else if (step) begin
      // data is only looked at when step is high, so an undriven bus on
      // idle cycles never reaches the signature.
      sig <= misr_step(sig, data, POLY);
    end
  end

endmodule

// File: rtl/resp_misr_checker.sv
// ---------------------------------------------------------------------------
// resp_misr_checker
//   Compresses NUM_SAMPLES accepted samples of the `top` output bus into a
//   MISR signature, then compares it once against exp_sig.
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   synchronous active-high reset
//     start        in   begin a new run (honoured in IDLE and DONE only)
//     sample_valid in   sample_data is valid this cycle
//     sample_data  in   sampled bus
//     exp_sig      in   expected signature, sampled in CHECK
//     busy         out  high in RUN and CHECK
//     done         out  high in DONE
//     pass         out  signature matched exp_sig (valid while done)
//     signature    out  current MISR value
//     count        out  samples accepted in this run
// ---------------------------------------------------------------------------
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int                DATA_W      = MISR_W,
  parameter int                NUM_SAMPLES = 21,
  parameter logic [DATA_W-1:0] POLY        = {{(DATA_W-8){1'b0}}, 8'h8E},
  parameter logic [DATA_W-1:0] SEED        = {DATA_W{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             sample_valid,
  input  logic [DATA_W-1:0]                sample_data,
  input  logic [DATA_W-1:0]                exp_sig,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [DATA_W-1:0]                signature,
  output logic [$clog2(NUM_SAMPLES+1)-1:0] count
);

  localparam int               CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t state;
  logic   accept;
  logic   load;

  // A sample is taken only while running; start only matters when no run is
  // in flight, so a stray start pulse can never truncate a run.
  assign accept = (state == RUN) && sample_valid;
  assign load   = ((state == IDLE) || (state == DONE)) && start;

  misr_reg #(
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (accept),
    .data (sample_data),
    .sig  (signature)
  );

  // NOTE: every case arm and every if without an else simply keeps the old
  // value; inside always_ff that is a register hold, not a latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (sample_valid) begin
            count <= count + ONE;
            // The last sample leaves RUN in the same edge, so count stops at
            // NUM_SAMPLES and never wraps.
            if (count == LAST) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          pass  <= (signature == exp_sig);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
